// File: rtl/instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Instruction prefetcher sitting between a core fetch port and a single-cycle
// instruction memory. It issues sequential word reads, queues the returned
// instructions in a small FIFO and hands them to the core with a valid/ready
// handshake. A branch strobe flushes the FIFO, redirects the fetch address and
// drops any stale response still on its way back.
//
// Ports
//   clk_i          : clock, all state updates on the rising edge
//   rst_ni         : asynchronous active-low reset
//   fetch_en_i     : high permits new memory requests
//   branch_i       : redirect strobe, branch_addr_i is the new byte address
//   branch_addr_i  : redirect byte address (bits [1:0] ignored)
//   instr_valid_o  : FIFO head available to the core
//   instr_rdata_o  : FIFO head instruction word (0 when empty)
//   instr_addr_o   : FIFO head byte address (0 when empty)
//   instr_ready_i  : core takes the head this cycle
//   mem_req_o      : read request to memory
//   mem_addr_o     : memory word address, fetch_addr[13:2]
//   mem_rdata_i    : memory read data
//   mem_rvalid_i   : read data valid, one cycle after an accepted request
//   busy_o         : request in flight or FIFO non-empty
//   stall_cnt_o    : (IFETCH_STALL_CNT_EN only) saturating count of cycles
//                    with fetch enabled but no instruction offered
//
// Parameters
//   DEPTH     : FIFO entries, power of two, >= 2
//   BOOT_ADDR : byte address of the first fetch after reset
//
// Optional feature macro: IFETCH_STALL_CNT_EN
// -----------------------------------------------------------------------------
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_ready_i,
  output logic        mem_req_o,
  output logic [11:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic        busy_o
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_addr_q, inflight_addr_d;
  logic          discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   addr_mem_q [DEPTH];

  logic          not_empty;
  logic          pop;
  logic          push;
  logic [CW:0]   credit_used;

  assign not_empty = (count_q != '0);

  // Head outputs are forced to zero when empty so the uninitialised storage
  // never leaks out (and reset reads back as zero).
  assign instr_valid_o = not_empty & ~branch_i;
  assign instr_rdata_o = not_empty ? data_mem_q[rd_ptr_q] : 32'h0;
  assign instr_addr_o  = not_empty ? addr_mem_q[rd_ptr_q] : 32'h0;
  assign busy_o        = inflight_q | not_empty;
  assign mem_addr_o    = fetch_addr_q[13:2];

  assign pop = instr_valid_o & instr_ready_i;

  // Slots already committed: stored entries plus the response in flight,
  // minus the one leaving this cycle. A new request is only issued when a
  // slot is guaranteed, so the FIFO can never overflow.
  assign credit_used = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);

  // rst_ni gates the request so memory sees no read while held in reset.
  assign mem_req_o = rst_ni & fetch_en_i & ~branch_i &
                     (credit_used < (CW+1)'(DEPTH));

  // A response arriving in a branch cycle belongs to the old stream.
  assign push = mem_rvalid_i & inflight_q & ~discard_q & ~branch_i;

  always_comb begin
    fetch_addr_d    = fetch_addr_q;
    inflight_d      = mem_req_o;
    inflight_addr_d = inflight_addr_q;
    discard_d       = discard_q;
    count_d         = count_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;

    if (mem_req_o) begin
      inflight_addr_d = fetch_addr_q;
      fetch_addr_d    = fetch_addr_q + 32'd4;
    end

    if (discard_q && mem_rvalid_i) begin
      discard_d = 1'b0;
    end

    if (branch_i) begin
      fetch_addr_d = {branch_addr_i[31:2], 2'b00};
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      // The stale response is normally dropped right here because it lands
      // in the branch cycle; only arm discard if it has not shown up yet.
      if (inflight_q && !mem_rvalid_i) begin
        discard_d = 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q    <= BOOT_ADDR;
      inflight_q      <= 1'b0;
      inflight_addr_q <= 32'h0;
      discard_q       <= 1'b0;
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      fetch_addr_q    <= fetch_addr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      discard_q       <= discard_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= mem_rdata_i;
      addr_mem_q[wr_ptr_q] <= inflight_addr_q;
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (fetch_en_i && !instr_valid_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_buffer
//
// Self-checking bench for instr_prefetch_buffer. A transaction-level model
// (queue of buffered instruction addresses, one pending-request flag and the
// expected next fetch address) predicts every cycle's outputs. The memory is
// modelled as a pure function of the word address. Directed scenario tasks
// add explicit checks for latency, back-pressure, branches, wrap and reset.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        branch;
  logic [31:0] branch_addr;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic [31:0] instr_addr;
  logic        instr_ready;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        busy;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instr_prefetch_buffer #(
    .DEPTH     (DEPTH),
    .BOOT_ADDR (BOOT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_en_i    (fetch_en),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .instr_valid_o (instr_valid),
    .instr_rdata_o (instr_rdata),
    .instr_addr_o  (instr_addr),
    .instr_ready_i (instr_ready),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata),
    .mem_rvalid_i  (mem_rvalid),
    .busy_o        (busy)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] mq[$];
  bit          pending;
  logic [31:0] pend_addr;
  logic [31:0] fptr;
  logic [31:0] stall_m;

  // per-cycle samples and delivered-instruction log (DUT values)
  logic        s_valid, s_req, s_busy;
  logic [31:0] s_addr;
  logic [11:0] s_maddr;
  logic [31:0] deliv[$];

  function automatic logic [31:0] memval(input logic [11:0] wa);
    return 32'hC0DE_0000 ^ {4'h5, wa, 4'hA, wa};
  endfunction

  task automatic model_reset();
    mq.delete();
    pending   = 1'b0;
    pend_addr = 32'h0;
    fptr      = BOOT;
    stall_m   = 32'h0;
  endtask

  // One clock cycle: sample at posedge+4, compare with the model, advance
  // the model, then drive the memory response at posedge+1.
  task automatic step();
    bit          exp_v, exp_r, exp_b, do_pop, nxt_rv;
    int          used;
    logic [31:0] head;
    logic [11:0] nxt_wa;
    #3;
    s_valid = instr_valid;
    s_req   = mem_req;
    s_busy  = busy;
    s_addr  = instr_addr;
    s_maddr = mem_addr;

    exp_v = (mq.size() != 0) && !branch;
    checks++;
    if (instr_valid !== exp_v) begin
      failures++;
      $display("FAIL valid t=%0t got=%b exp=%b", $time, instr_valid, exp_v);
    end
    if (exp_v) begin
      head = mq[0];
      checks++;
      if (instr_addr !== head) begin
        failures++;
        $display("FAIL instr_addr t=%0t got=%h exp=%h", $time, instr_addr, head);
      end
      checks++;
      if (instr_rdata !== memval(head[13:2])) begin
        failures++;
        $display("FAIL instr_rdata t=%0t got=%h exp=%h", $time, instr_rdata,
                 memval(head[13:2]));
      end
    end

    do_pop = exp_v && instr_ready;
    used   = mq.size() + int'(pending) - int'(do_pop);
    exp_r  = fetch_en && !branch && (used < DEPTH);
    checks++;
    if (mem_req !== exp_r) begin
      failures++;
      $display("FAIL mem_req t=%0t got=%b exp=%b", $time, mem_req, exp_r);
    end
    if (mem_req === 1'b1) begin
      checks++;
      if (mem_addr !== fptr[13:2]) begin
        failures++;
        $display("FAIL mem_addr t=%0t got=%h exp=%h", $time, mem_addr, fptr[13:2]);
      end
    end

    exp_b = pending || (mq.size() != 0);
    checks++;
    if (busy !== exp_b) begin
      failures++;
      $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, exp_b);
    end

`ifdef IFETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== stall_m) begin
      failures++;
      $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, stall_m);
    end
    if (fetch_en && !exp_v && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
`endif

    if (instr_valid === 1'b1 && instr_ready) deliv.push_back(instr_addr);
    if (do_pop) void'(mq.pop_front());
    if (mem_rvalid && pending && !branch) mq.push_back(pend_addr);
    pending   = (mem_req === 1'b1);
    pend_addr = fptr;
    if (branch) begin
      mq.delete();
      fptr = {branch_addr[31:2], 2'b00};
    end else if (mem_req === 1'b1) begin
      fptr = fptr + 32'd4;
    end
    nxt_rv = (mem_req === 1'b1);
    nxt_wa = mem_addr;

    @(posedge clk);
    #1;
    mem_rvalid = nxt_rv;
    mem_rdata  = nxt_rv ? memval(nxt_wa) : 32'h0;
  endtask

  // Asserts reset mid-cycle (no clock edge before the check, so the outputs
  // must clear asynchronously), holds it, releases at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got valid=%b req=%b busy=%b exp=0/0/0",
               instr_valid, mem_req, busy);
    end
    checks++;
    if (instr_rdata !== 32'h0 || instr_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got rdata=%h addr=%h exp=0/0", instr_rdata, instr_addr);
    end
    checks++;
    if (mem_addr !== fptr_boot_wa()) begin
      failures++;
      $display("FAIL reset_mem_addr got=%h exp=%h", mem_addr, fptr_boot_wa());
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    branch     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [11:0] fptr_boot_wa();
    logic [31:0] b;
    b = BOOT;
    return b[13:2];
  endfunction

  task automatic test_reset();
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    branch_addr = 32'h0;
    do_reset();
    // Garbage response in the first cycle after release must be ignored.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    step();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_rvalid got valid=%b exp=0", s_valid);
    end
  endtask

  task automatic test_startup();
    logic        v[6];
    logic [11:0] a[6];
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    deliv.delete();
    for (int c = 0; c < 6; c++) begin
      step();
      v[c] = s_valid;
      a[c] = s_maddr;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (a[c] !== 12'(c)) begin
        failures++;
        $display("FAIL startup_mem_addr c=%0d got=%h exp=%h", c, a[c], 12'(c));
      end
    end
    checks++;
    if (v[0] !== 1'b0 || v[1] !== 1'b0 || v[2] !== 1'b1 || v[3] !== 1'b1) begin
      failures++;
      $display("FAIL startup_latency got=%b%b%b%b exp=0011", v[0], v[1], v[2], v[3]);
    end
    checks++;
    if (deliv.size() < 3) begin
      failures++;
      $display("FAIL startup_count got=%0d exp>=3", deliv.size());
    end else if (deliv[0] !== 32'h0 || deliv[1] !== 32'h4 || deliv[2] !== 32'h8) begin
      failures++;
      $display("FAIL startup_addr got=%h,%h,%h exp=0,4,8", deliv[0], deliv[1], deliv[2]);
    end
  endtask

  task automatic test_backpressure();
    int got;
    fetch_en    = 1'b1;
    instr_ready = 1'b0;
    repeat (10) step();
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1 || s_busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got req=%b valid=%b busy=%b exp=0/1/1", s_req, s_valid, s_busy);
    end
    // Drain with fetching disabled: exactly DEPTH entries must come out.
    fetch_en    = 1'b0;
    instr_ready = 1'b1;
    deliv.delete();
    repeat (4) step();
    got = deliv.size();
    checks++;
    if (got != DEPTH) begin
      failures++;
      $display("FAIL bp_stored got=%0d exp=%0d", got, DEPTH);
    end else if (deliv[1] !== deliv[0] + 32'd4) begin
      failures++;
      $display("FAIL bp_order got=%h,%h exp consecutive", deliv[0], deliv[1]);
    end
    fetch_en = 1'b1;
    step();
    checks++;
    if (s_req !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume got req=%b exp=1", s_req);
    end
    repeat (3) step();
  endtask

  task automatic test_branch();
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    repeat (4) step();
    branch      = 1'b1;
    branch_addr = 32'h0000_0103;
    step();
    branch = 1'b0;
    step();
    checks++;
    if (s_req !== 1'b1 || s_maddr !== 12'h040 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL branch_c1 got req=%b addr=%h valid=%b exp=1/040/0", s_req, s_maddr, s_valid);
    end
    step();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL branch_c2 got valid=%b exp=0", s_valid);
    end
    step();
    checks++;
    if (s_valid !== 1'b1 || s_addr !== 32'h0000_0100) begin
      failures++;
      $display("FAIL branch_c3 got valid=%b addr=%h exp=1/00000100", s_valid, s_addr);
    end
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    repeat (3) step();
    branch      = 1'b1;
    branch_addr = 32'h0000_0200;
    step();
    branch_addr = 32'h0000_0300;
    step();
    branch = 1'b0;
    deliv.delete();
    repeat (6) step();
    checks++;
    if (deliv.size() != 4) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=4", deliv.size());
    end else if (deliv[0] !== 32'h300 || deliv[1] !== 32'h304 ||
                 deliv[2] !== 32'h308 || deliv[3] !== 32'h30C) begin
      failures++;
      $display("FAIL b2b_addr got=%h,%h,%h,%h exp=300,304,308,30c",
               deliv[0], deliv[1], deliv[2], deliv[3]);
    end
  endtask

  task automatic test_wrap();
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    branch      = 1'b1;
    branch_addr = 32'hFFFF_FFFA;
    step();
    branch = 1'b0;
    deliv.delete();
    repeat (6) step();
    checks++;
    if (deliv.size() < 4) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp>=4", deliv.size());
    end else if (deliv[0] !== 32'hFFFF_FFF8 || deliv[1] !== 32'hFFFF_FFFC ||
                 deliv[2] !== 32'h0 || deliv[3] !== 32'h4) begin
      failures++;
      $display("FAIL wrap_addr got=%h,%h,%h,%h exp=fffffff8,fffffffc,0,4",
               deliv[0], deliv[1], deliv[2], deliv[3]);
    end
  endtask

  task automatic test_fetch_disable();
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    repeat (3) step();
    fetch_en = 1'b0;
    step();
    checks++;
    if (s_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_dis_req got=%b exp=0", s_req);
    end
    repeat (2) step();
    checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL fetch_dis_drain got valid=%b busy=%b exp=0/0", s_valid, s_busy);
    end
    fetch_en = 1'b1;
  endtask

  task automatic test_reset_midstream();
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    repeat (3) step();
    instr_ready = 1'b0;
    repeat (4) step();
    checks++;
    if (s_valid !== 1'b1 || s_req !== 1'b0) begin
      failures++;
      $display("FAIL mid_full got valid=%b req=%b exp=1/0", s_valid, s_req);
    end
    instr_ready = 1'b1;
    do_reset();
    step();
    checks++;
    if (s_req !== 1'b1 || s_maddr !== fptr_boot_wa()) begin
      failures++;
      $display("FAIL mid_boot got req=%b addr=%h exp=1/%h", s_req, s_maddr, fptr_boot_wa());
    end
    repeat (3) step();
  endtask

`ifdef IFETCH_STALL_CNT_EN
  task automatic test_stall_cnt();
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    step();
    step();
    step();
    checks++;
    if (s_valid !== 1'b1 || stall_cnt !== 32'd2) begin
      failures++;
      $display("FAIL stall_first got valid=%b cnt=%0d exp=1/2", s_valid, stall_cnt);
    end
    repeat (3) step();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      fetch_en    = ($urandom_range(0, 7) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      branch      = ($urandom_range(0, 15) == 0);
      branch_addr = $urandom;
      step();
    end
    branch = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    branch      = 1'b0;
    branch_addr = 32'h0;
    instr_ready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_startup();
    test_backpressure();
    test_branch();
    test_back_to_back();
    test_wrap();
    test_fetch_disable();
    test_reset_midstream();
`ifdef IFETCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
